// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl: frames the uart_reciever byte stream (SYNC, LEN, payload, CHK)
// and releases checked payload over a valid/ready stream.
module uart_rx_frame_ctrl #(
    parameter int unsigned MAX_LEN      = 16,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
    parameter int unsigned TIMEOUT_CLKS = 208320
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_Rx_DV,
    input  logic [7:0] i_Rx_Byte,
    output logic       o_Data_Valid,
    output logic [7:0] o_Data_Byte,
    output logic       o_Data_Last,
    input  logic       i_Data_Ready,
    output logic       o_Err_Length,
    output logic       o_Err_Checksum,
    output logic       o_Err_Timeout,
    output logic       o_Err_Overrun
);

    localparam int IW    = $clog2(MAX_LEN + 1);
    localparam int AW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int DEPTH = 1 << AW;
    localparam int TW    = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;

    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CLKS - 1);
    localparam logic [7:0]    MAX_B  = 8'(MAX_LEN);

    typedef enum logic [2:0] {
        S_HUNT,
        S_LEN,
        S_PAYLOAD,
        S_CHECK,
        S_OUTPUT
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] len_q, len_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [IW-1:0] rd_q, rd_d;
    logic [7:0]    chk_q, chk_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          err_len_q, err_len_d;
    logic          err_chk_q, err_chk_d;
    logic          err_to_q, err_to_d;
    logic          err_ovr_q, err_ovr_d;
    logic          wr_en;

    logic [7:0]    pay_mem [DEPTH];
    logic [IW-1:0] idx_inc;
    logic [IW-1:0] rd_inc;
    logic          in_frame;
    logic          is_last;

    assign idx_inc  = idx_q + IW'(1);
    assign rd_inc   = rd_q + IW'(1);
    assign in_frame = (state_q == S_LEN) || (state_q == S_PAYLOAD)
                   || (state_q == S_CHECK);
    assign is_last  = (rd_inc == len_q);

    // Drain port is driven only while a checked frame is being released.
    assign o_Data_Valid   = (state_q == S_OUTPUT);
    assign o_Data_Byte    = o_Data_Valid ? pay_mem[rd_q[AW-1:0]] : 8'h00;
    assign o_Data_Last    = o_Data_Valid && is_last;
    assign o_Err_Length   = err_len_q;
    assign o_Err_Checksum = err_chk_q;
    assign o_Err_Timeout  = err_to_q;
    assign o_Err_Overrun  = err_ovr_q;

    // Next-state, frame bookkeeping and error pulse generation.
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        idx_d     = idx_q;
        rd_d      = rd_q;
        chk_d     = chk_q;
        timer_d   = '0;
        err_len_d = 1'b0;
        err_chk_d = 1'b0;
        err_to_d  = 1'b0;
        err_ovr_d = 1'b0;
        wr_en     = 1'b0;

        unique case (state_q)
            S_HUNT: begin
                if (i_Rx_DV && (i_Rx_Byte == SYNC_BYTE)) begin
                    state_d = S_LEN;
                end
            end
            S_LEN: begin
                if (i_Rx_DV) begin
                    if ((i_Rx_Byte == 8'h00) || (i_Rx_Byte > MAX_B)) begin
                        err_len_d = 1'b1;
                        state_d   = S_HUNT;
                    end else begin
                        len_d   = IW'(i_Rx_Byte);
                        chk_d   = i_Rx_Byte;
                        idx_d   = '0;
                        state_d = S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                if (i_Rx_DV) begin
                    wr_en = 1'b1;
                    chk_d = chk_q ^ i_Rx_Byte;
                    idx_d = idx_inc;
                    if (idx_inc == len_q) begin
                        state_d = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                if (i_Rx_DV) begin
                    if (i_Rx_Byte == chk_q) begin
                        rd_d    = '0;
                        state_d = S_OUTPUT;
                    end else begin
                        err_chk_d = 1'b1;
                        state_d   = S_HUNT;
                    end
                end
            end
            S_OUTPUT: begin
                // Bytes cannot be buffered while draining; they are dropped.
                err_ovr_d = i_Rx_DV;
                if (i_Data_Ready) begin
                    if (is_last) begin
                        rd_d    = '0;
                        state_d = S_HUNT;
                    end else begin
                        rd_d = rd_inc;
                    end
                end
            end
            default: begin
                state_d = S_HUNT;
            end
        endcase

        // A byte on the expiry cycle takes priority over the timeout.
        if (in_frame && !i_Rx_DV) begin
            if (timer_q == T_LAST) begin
                err_to_d = 1'b1;
                state_d  = S_HUNT;
            end else begin
                timer_d = timer_q + TW'(1);
            end
        end
    end

    // State and control registers.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q   <= S_HUNT;
            len_q     <= '0;
            idx_q     <= '0;
            rd_q      <= '0;
            chk_q     <= '0;
            timer_q   <= '0;
            err_len_q <= 1'b0;
            err_chk_q <= 1'b0;
            err_to_q  <= 1'b0;
            err_ovr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            rd_q      <= rd_d;
            chk_q     <= chk_d;
            timer_q   <= timer_d;
            err_len_q <= err_len_d;
            err_chk_q <= err_chk_d;
            err_to_q  <= err_to_d;
            err_ovr_q <= err_ovr_d;
        end
    end

    // Payload buffer; contents are only read after a full frame is checked.
    always_ff @(posedge i_Clock) begin
        if (wr_en) begin
            pay_mem[idx_q[AW-1:0]] <= i_Rx_Byte;
        end
    end

endmodule
